dp_issue_sequencer: RTL and testbench

- Upstream stage of Datapath: buffers packed ALU instructions in a small FIFO and issues one per cycle as registered controls (wr, addr1/2/3, ALUControl).
- Run/drain/flush state machine plus an issue counter.
- Optional capture of the datapath write-back result.

---
 rtl/dp_pkg.sv | 44 ++++
 rtl/dp_issue_sequencer_if.sv | 12 +
 rtl/dp_instr_fifo.sv | 50 +++++
 rtl/dp_issue_sequencer.sv | 122 ++++++++++++
 tb/tb_dp_issue_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the Datapath issue sequencer: instruction layout,
// datapath widths and the sequencer FSM state type.
package dp_pkg;

    localparam int INSTR_W = 10;
    localparam int ADDR_W  = 2;
    localparam int ALU_W   = 3;
    localparam int DATA_W  = 32;

    localparam int WB_BIT  = 9;
    localparam int ALU_MSB = 8;
    localparam int ALU_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 2;
    localparam int RS1_MSB = 1;
    localparam int RS1_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic              wb;
        logic [ALU_W-1:0]  alu_ctrl;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rs1;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] raw);
        instr_t f;
        f.wb       = raw[WB_BIT];
        f.alu_ctrl = raw[ALU_MSB:ALU_LSB];
        f.rd       = raw[RD_MSB:RD_LSB];
        f.rs2      = raw[RS2_MSB:RS2_LSB];
        f.rs1      = raw[RS1_MSB:RS1_LSB];
        return f;
    endfunction

endpackage

// File: rtl/dp_issue_sequencer_if.sv
// Valid/ready instruction stream into the issue sequencer.
interface dp_issue_sequencer_if;
    import dp_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/dp_instr_fifo.sv
// DEPTH-entry synchronous instruction FIFO; flush empties it and
// overrides any push or pop in the same cycle.
module dp_instr_fifo
    import dp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dp_issue_sequencer.sv
// Buffers packed ALU instructions and issues one per cycle as registered
// Datapath controls. Define DP_ISSUE_RESULT_CAPTURE_EN to capture write-back results.
module dp_issue_sequencer
    import dp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dp_issue_sequencer_if.slave   in_if,
    input  logic                  run,
    input  logic                  flush,
    output logic                  busy,
    output logic                  dp_wr,
    output logic [ADDR_W-1:0]     dp_addr1,
    output logic [ADDR_W-1:0]     dp_addr2,
    output logic [ADDR_W-1:0]     dp_addr3,
    output logic [ALU_W-1:0]      dp_alu_ctrl,
    input  logic [DATA_W-1:0]     dp_result,
    output logic [CNT_W-1:0]      issue_count,
    output logic                  res_valid,
    output logic [DATA_W-1:0]     res_data
);

    localparam int AW = $clog2(DEPTH);

    seq_state_e         state, state_next;
    logic               fifo_full, fifo_empty;
    logic [AW:0]        fifo_count;
    logic [AW:0]        occ_next;
    logic [INSTR_W-1:0] head;
    logic               push, issue;
    instr_t             head_f;

    // Full blocks a push even when a pop frees a slot the same cycle.
    assign in_if.in_ready = !fifo_full && !flush;
    assign push  = in_if.in_valid && in_if.in_ready;
    assign issue = (state != IDLE) && !fifo_empty && !flush;
    assign busy  = (state != IDLE);

    dp_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .flush (flush),
        .din   (in_if.in_instr),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign occ_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    assign head_f   = unpack_instr(head);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:       if (run) state_next = RUN;
                RUN, DRAIN: begin
                    if (run)                 state_next = RUN;
                    else if (occ_next != '0) state_next = DRAIN;
                    else                     state_next = IDLE;
                end
                default:    state_next = IDLE;
            endcase
        end
    end

    // Issue stage: a cycle without a pop drives a bubble so dp_wr never repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_wr       <= 1'b0;
            dp_addr1    <= '0;
            dp_addr2    <= '0;
            dp_addr3    <= '0;
            dp_alu_ctrl <= '0;
            issue_count <= '0;
        end else if (issue) begin
            dp_wr       <= head_f.wb;
            dp_addr1    <= head_f.rs1;
            dp_addr2    <= head_f.rs2;
            dp_addr3    <= head_f.rd;
            dp_alu_ctrl <= head_f.alu_ctrl;
            issue_count <= issue_count + CNT_W'(1);
        end else begin
            dp_wr       <= 1'b0;
            dp_addr1    <= '0;
            dp_addr2    <= '0;
            dp_addr3    <= '0;
            dp_alu_ctrl <= '0;
        end
    end

`ifdef DP_ISSUE_RESULT_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= dp_wr;
            if (dp_wr) res_data <= dp_result;
        end
    end
`else
    logic unused_result;
    assign unused_result = ^dp_result;
    assign res_valid     = 1'b0;
    assign res_data      = '0;
`endif

endmodule

// File: tb/tb_dp_issue_sequencer.sv
// Randomized and directed check of dp_issue_sequencer against a queue-based
// reference model of the issue rules (honours DP_ISSUE_RESULT_CAPTURE_EN).
module tb_dp_issue_sequencer;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DRN  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        dp_wr;
    logic [1:0]  dp_addr1, dp_addr2, dp_addr3;
    logic [2:0]  dp_alu_ctrl;
    logic [31:0] dp_result = 32'h0;
    logic [15:0] issue_count;
    logic        res_valid;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;

    dp_issue_sequencer_if ifc ();

    dp_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (ifc.slave),
        .run         (run),
        .flush       (flush),
        .busy        (busy),
        .dp_wr       (dp_wr),
        .dp_addr1    (dp_addr1),
        .dp_addr2    (dp_addr2),
        .dp_addr3    (dp_addr3),
        .dp_alu_ctrl (dp_alu_ctrl),
        .dp_result   (dp_result),
        .issue_count (issue_count),
        .res_valid   (res_valid),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending instructions plus expected outputs.
    logic [9:0]  q[$];
    int          mode;
    logic        e_wr;
    logic [1:0]  e_a1, e_a2, e_a3;
    logic [2:0]  e_alu;
    logic [15:0] e_cnt;
    logic        e_rv;
    logic [31:0] e_rd;

    task automatic model_reset();
        q.delete();
        mode  = M_IDLE;
        e_wr  = 1'b0; e_a1 = '0; e_a2 = '0; e_a3 = '0; e_alu = '0;
        e_cnt = '0;
        e_rv  = 1'b0; e_rd = '0;
    endtask

    task automatic model_edge(input logic v, input logic [9:0] ins, input logic r,
                              input logic f, input logic [31:0] res);
        logic       ready, iss;
        logic [9:0] h;
        ready = (q.size() < DEPTH) && !f;
        iss   = (mode != M_IDLE) && (q.size() > 0) && !f;
`ifdef DP_ISSUE_RESULT_CAPTURE_EN
        e_rv = e_wr;
        if (e_wr) e_rd = res;
`endif
        e_wr = 1'b0; e_a1 = '0; e_a2 = '0; e_a3 = '0; e_alu = '0;
        if (f) begin
            q.delete();
            mode = M_IDLE;
        end else begin
            if (iss) begin
                h     = q.pop_front();
                e_wr  = h[9];
                e_alu = h[8:6];
                e_a3  = h[5:4];
                e_a2  = h[3:2];
                e_a1  = h[1:0];
                e_cnt = e_cnt + 16'd1;
            end
            if (v && ready) q.push_back(ins);
            if (r)                  mode = M_RUN;
            else if (mode == M_IDLE) mode = M_IDLE;
            else if (q.size() > 0)  mode = M_DRN;
            else                    mode = M_IDLE;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",    32'(ifc.in_ready),  32'((q.size() < DEPTH) && !flush));
        chk("busy",        32'(busy),          32'(mode != M_IDLE));
        chk("dp_wr",       32'(dp_wr),         32'(e_wr));
        chk("dp_addr1",    32'(dp_addr1),      32'(e_a1));
        chk("dp_addr2",    32'(dp_addr2),      32'(e_a2));
        chk("dp_addr3",    32'(dp_addr3),      32'(e_a3));
        chk("dp_alu_ctrl", 32'(dp_alu_ctrl),   32'(e_alu));
        chk("issue_count", 32'(issue_count),   32'(e_cnt));
        chk("res_valid",   32'(res_valid),     32'(e_rv));
        chk("res_data",    res_data,           e_rd);
    endtask

    task automatic step(input logic v, input logic [9:0] ins, input logic r,
                        input logic f, input logic [31:0] res);
        ifc.in_valid = v;
        ifc.in_instr = ins;
        run          = r;
        flush        = f;
        dp_result    = res;
        model_edge(v, ins, r, f, res);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic        rl;
        logic [15:0] base;
        int          guard;

        // Reset held with traffic offered.
        ifc.in_valid = 1'b1;
        ifc.in_instr = 10'h224;
        run          = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dp_wr",    32'(dp_wr),          32'd0);
        chk("rst_count",    32'(issue_count),    32'd0);
        chk("rst_busy",     32'(busy),           32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready),   32'd1);
        chk("rst_res_valid",32'(res_valid),      32'd0);
        ifc.in_valid = 1'b0;
        run          = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Single issue, then the write-back result capture.
        step(1'b1, 10'h224, 1'b1, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'hDEADBEEF);
        chk("single_wr",  32'(dp_wr),       32'd1);
        chk("single_rd",  32'(dp_addr3),    32'd2);
        chk("single_rs2", 32'(dp_addr2),    32'd1);
        chk("single_cnt", 32'(issue_count), 32'd1);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'hDEADBEEF);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h12345678);

        // wb=0 instruction must not set res_valid.
        step(1'b1, 10'h0E5, 1'b1, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'hAAAA5555);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'hAAAA5555);
        chk("wb0_res_valid", 32'(res_valid), 32'd0);

        // Backpressure: five pushes against a stopped sequencer.
        base = issue_count;
        for (int i = 0; i < 4; i++) step(1'b1, 10'(10'h200 + i), 1'b0, 1'b0, 32'(i));
        chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        step(1'b1, 10'h3FF, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (q.size() < DEPTH && guard < 0) guard++;
        rl = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 10'h3FF, rl, 1'b0, 32'(i));
        // Stop feeding the 5th copy once it has been queued.
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 10'h000, 1'b1, 1'b0, 32'h0);
        chk("full_total", 32'(issue_count - base) >= 32'd5 ? 32'd1 : 32'd0, 32'd1);

        // Drain: three queued, run high for one cycle then low.
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
        base = issue_count;
        for (int i = 0; i < 3; i++) step(1'b1, 10'(10'h240 + i), 1'b0, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
        chk("drain_busy", 32'(busy), 32'd1);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
        chk("drain_count", 32'(issue_count - base), 32'd3);
        chk("drain_idle",  32'(busy),               32'd0);

        // Flush while running with an offered push.
        for (int i = 0; i < 3; i++) step(1'b1, 10'(10'h300 + i), 1'b0, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'h0);
        base = issue_count;
        step(1'b1, 10'h3C3, 1'b1, 1'b1, 32'h0);
        chk("flush_no_issue", 32'(dp_wr), 32'd0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'h0);
        chk("flush_dropped", 32'(issue_count - base), 32'd0);

        // Randomized traffic.
        rl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) rl = ~rl;
            step(($urandom_range(3) != 0), 10'($urandom), rl,
                 ($urandom_range(39) == 0), $urandom);
        end

        // Mid-operation asynchronous reset while issuing.
        for (int i = 0; i < 3; i++) step(1'b1, 10'(10'h200 | i), 1'b1, 1'b0, 32'h0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_dp_wr", 32'(dp_wr),       32'd0);
        chk("midrst_count", 32'(issue_count), 32'd0);
        chk("midrst_busy",  32'(busy),        32'd0);
        ifc.in_valid = 1'b0;
        run          = 1'b0;
        flush        = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_all();
        step(1'b1, 10'h224, 1'b1, 1'b0, 32'h0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 32'hCAFEF00D);
        step(1'b0, 10'h000, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
